// File: rtl/fpga_uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package fpga_uart_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  len;
    } tx_frame_t;

    // Byte idx of a frame, byte 0 in the least significant position.
    function automatic logic [7:0] frame_byte(input logic [31:0] data, input logic [1:0] idx);
        return data[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fpga_rr_arbiter.sv
// Combinational round-robin pick: search starts one past rr_ptr and wraps.
module fpga_rr_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       any_req,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] ptr, input int unsigned k);
        return PTR_W'((32'(ptr) + k) % NUM_REQ);
    endfunction

    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!any_req && req[rr_index(rr_ptr, k)]) begin
                any_req = 1'b1;
                winner  = rr_index(rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/fpga_uart_tx_arbiter.sv
// Shares one UART transmitter between several frame sources, one whole frame at a time,
// LSB first, with a per-byte watchdog on tx_done.
module fpga_uart_tx_arbiter
    import fpga_uart_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned PTR_W          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    input  logic [NUM_REQ*2-1:0] req_len,
    output logic [NUM_REQ-1:0]   req_ack,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic [PTR_W-1:0]     grant_id,
    output logic [1:0]           arb_state,
    output logic                 tx_timeout
);

    localparam int unsigned    WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state;
    tx_frame_t        frame;
    logic [1:0]       byte_idx;
    logic [WD_W-1:0]  wdog;
    logic [PTR_W-1:0] rr_ptr;
    logic             any_req;
    logic [PTR_W-1:0] winner;

    fpga_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .winner  (winner)
    );

    assign arb_state = state;

    // tx_done in the tx_start cycle belongs to the previous byte and is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame      <= '0;
            byte_idx   <= '0;
            wdog       <= '0;
            rr_ptr     <= PTR_W'(NUM_REQ - 1);
            req_ack    <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            tx_timeout <= 1'b0;
        end else begin
            req_ack  <= '0;
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        frame.data      <= req_data[32'(winner)*32 +: 32];
                        frame.len       <= req_len[32'(winner)*2 +: 2];
                        byte_idx        <= '0;
                        grant_id        <= winner;
                        req_ack[winner] <= 1'b1;
                        state           <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= frame_byte(frame.data, byte_idx);
                        wdog     <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_done && !tx_start) begin
                        if (byte_idx == frame.len) begin
                            rr_ptr <= grant_id;
                            state  <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= SEND;
                        end
                    end else if (wdog == WD_LAST) begin
                        tx_timeout <= 1'b1;
                        rr_ptr     <= grant_id;
                        state      <= IDLE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
